// File: rtl/sensor_mod5_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_mod5_scheduler
//
// Purpose:
//   Time-shares one external combinational mod-5 remainder unit between
//   NUM_SENSORS requesting sensor channels. A round-robin arbiter grants one
//   channel at a time. The block registers that channel's 4-bit word onto
//   sensor_input. It captures the returned remainder one cycle later. It then
//   presents the remainder, tagged with the channel id, on a valid/ready
//   result port. Each transaction walks IDLE -> CAPTURE -> HOLD -> IDLE, so
//   results come out at most once every three cycles.
//
// Ports:
//   clk          in   1               rising-edge clock
//   rst          in   1               synchronous reset, active-high
//   req          in   NUM_SENSORS     per-channel request level, held until ack
//   sensor_data  in   4*NUM_SENSORS   channel i word on [4*i+3:4*i]
//   ack          out  NUM_SENSORS     one-cycle pulse: channel word sampled
//   sensor_input out  4               registered operand to the shared unit
//   rest         in   3               remainder from the shared unit
//   res_valid    out  1               result available
//   res_ready    in   1               consumer accepts when res_valid & res_ready
//   res_rest     out  3               captured remainder
//   res_ch       out  CH_W            channel id that produced res_rest
//   res_zero     out  1               res_rest == 0
//   done_count   out  CNT_W           accepted results, saturating
//   err          out  1               sticky: shared unit returned rest > 4
// -----------------------------------------------------------------------------
module sensor_mod5_scheduler #(
    parameter int NUM_SENSORS = 4,
    parameter int CH_W        = 2,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SENSORS-1:0]   req,
    input  logic [4*NUM_SENSORS-1:0] sensor_data,
    output logic [NUM_SENSORS-1:0]   ack,
    output logic [3:0]               sensor_input,
    input  logic [2:0]               rest,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2:0]               res_rest,
    output logic [CH_W-1:0]          res_ch,
    output logic                     res_zero,
    output logic [CNT_W-1:0]         done_count,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [CH_W-1:0]          rr_ptr_r;
    logic [CH_W-1:0]          cur_ch_r;
    logic [CH_W-1:0]          grant_ch_s;
    logic                     grant_s;
    logic                     accept_s;
    logic [NUM_SENSORS-1:0]   ack_r;
    logic [3:0]               sensor_input_r;
    logic                     res_valid_r;
    logic [2:0]               res_rest_r;
    logic [CH_W-1:0]          res_ch_r;
    logic                     res_zero_r;
    logic [CNT_W-1:0]         done_count_r;
    logic                     err_r;

    // Channel index base+k folded back into 0..NUM_SENSORS-1 (k < NUM_SENSORS).
    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_SENSORS) begin
            sum = sum - NUM_SENSORS;
        end else begin
            sum = sum;
        end
        return CH_W'(sum);
    endfunction

    // Successor channel; NUM_SENSORS need not be a power of two, so wrap explicitly.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        logic [CH_W-1:0] nxt;
        if (ch == CH_W'(NUM_SENSORS - 1)) begin
            nxt = {CH_W{1'b0}};
        end else begin
            nxt = ch + {{(CH_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // A legal mod-5 remainder is 0..4; anything above flags a faulty shared unit.
    function automatic logic rest_invalid(input logic [2:0] r);
        return (r > 3'd4);
    endfunction

    // Round-robin pick: scan from the far end back towards rr_ptr so the
    // last writer is the first requester at or after rr_ptr.
    always_comb begin
        grant_s    = |req;
        grant_ch_s = {CH_W{1'b0}};
        for (int k = NUM_SENSORS - 1; k >= 0; k--) begin
            grant_ch_s = req[rr_index(rr_ptr_r, k)] ? rr_index(rr_ptr_r, k) : grant_ch_s;
        end
    end

    // Next-state logic and result handshake detection.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = IDLE;
                end
            end
            CAPTURE: begin
                state_s = HOLD;
            end
            HOLD: begin
                if (res_valid_r && res_ready) begin
                    accept_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s  = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand launch, remainder capture, result hold and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r       <= {CH_W{1'b0}};
            cur_ch_r       <= {CH_W{1'b0}};
            ack_r          <= {NUM_SENSORS{1'b0}};
            sensor_input_r <= 4'd0;
            res_valid_r    <= 1'b0;
            res_rest_r     <= 3'd0;
            res_ch_r       <= {CH_W{1'b0}};
            res_zero_r     <= 1'b0;
            done_count_r   <= {CNT_W{1'b0}};
            err_r          <= 1'b0;
        end else begin
            // ack is a single-cycle pulse following the grant edge.
            ack_r <= {NUM_SENSORS{1'b0}};
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        sensor_input_r <= sensor_data[{grant_ch_s, 2'b00} +: 4];
                        cur_ch_r       <= grant_ch_s;
                        ack_r          <= {{(NUM_SENSORS-1){1'b0}}, 1'b1} << grant_ch_s;
                    end else begin
                        sensor_input_r <= sensor_input_r;
                    end
                end
                CAPTURE: begin
                    res_rest_r  <= rest;
                    res_ch_r    <= cur_ch_r;
                    res_zero_r  <= (rest == 3'd0);
                    res_valid_r <= 1'b1;
                    err_r       <= err_r | rest_invalid(rest);
                end
                HOLD: begin
                    if (accept_s) begin
                        res_valid_r  <= 1'b0;
                        done_count_r <= sat_inc(done_count_r);
                        rr_ptr_r     <= next_ch(cur_ch_r);
                    end else begin
                        res_valid_r  <= res_valid_r;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack          = ack_r;
    assign sensor_input = sensor_input_r;
    assign res_valid    = res_valid_r;
    assign res_rest     = res_rest_r;
    assign res_ch       = res_ch_r;
    assign res_zero     = res_zero_r;
    assign done_count   = done_count_r;
    assign err          = err_r;

endmodule

// File: tb/tb_sensor_mod5_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sensor_mod5_scheduler
//
// Purpose:
//   Self-checking bench for sensor_mod5_scheduler. The bench models the
//   shared mod-5 unit. That model can be forced to return 6. The bench also
//   models well-behaved requesters that drop req on ack. Expected results
//   go into a queue when a request is posted. Each entry is popped and
//   compared when the DUT completes a valid/ready handshake.
// -----------------------------------------------------------------------------
module tb_sensor_mod5_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] sensor_data;
    logic [3:0]  ack;
    logic [3:0]  sensor_input;
    logic [2:0]  rest;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_rest;
    logic [1:0]  res_ch;
    logic        res_zero;
    logic [7:0]  done_count;
    logic        err;

    logic        bad;
    logic        auto_drop;
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_done = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic [2:0] rest;
        logic       zero;
    } exp_t;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] data;
        logic [2:0] rest;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[12];

    sensor_mod5_scheduler #(
        .NUM_SENSORS(4),
        .CH_W(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .sensor_data(sensor_data),
        .ack(ack),
        .sensor_input(sensor_input),
        .rest(rest),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_rest(res_rest),
        .res_ch(res_ch),
        .res_zero(res_zero),
        .done_count(done_count),
        .err(err)
    );

    always #5 clk = ~clk;

    // Shared mod-5 unit stub, optionally faulty.
    assign rest = bad ? 3'd6 : 3'(sensor_input % 4'd5);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: score a handshake that the coming edge will take, advance,
    // then let the requesters react to ack.
    task automatic tick();
        exp_t e;
        if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got ch %0d rest %0d expected none", res_ch, res_rest);
            end else begin
                e = exp_q.pop_front();
                check("res_ch", 32'(res_ch), 32'(e.ch));
                check("res_rest", 32'(res_rest), 32'(e.rest));
                check("res_zero", 32'(res_zero), 32'(e.zero));
                if (exp_done < 255) exp_done++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic post(input int ch, input logic [3:0] d, input logic [2:0] r);
        exp_t e;
        sensor_data[4*ch +: 4] = d;
        req[ch] = 1'b1;
        e.ch   = 2'(ch);
        e.rest = r;
        e.zero = (r == 3'd0);
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || res_valid || req != 4'd0) && t < budget) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0 || res_valid || req != 4'd0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d results pending expected 0 after %0d cycles", exp_q.size(), budget);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_sensor_input"}, 32'(sensor_input), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_rest"}, 32'(res_rest), 32'd0);
        check({tag, "_res_ch"}, 32'(res_ch), 32'd0);
        check({tag, "_res_zero"}, 32'(res_zero), 32'd0);
        check({tag, "_done_count"}, 32'(done_count), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] d;
        rst = 1'b1; req = 4'd0; sensor_data = 16'd0; res_ready = 1'b0;
        bad = 1'b0; auto_drop = 1'b1;

        // Single-channel vectors {ch, data, expected remainder}; first is the basic ch0 case.
        vecs[0]  = '{2'd0, 4'd6,  3'd1};
        vecs[1]  = '{2'd1, 4'd0,  3'd0};
        vecs[2]  = '{2'd2, 4'd15, 3'd0};
        vecs[3]  = '{2'd3, 4'd14, 3'd4};
        vecs[4]  = '{2'd0, 4'd5,  3'd0};
        vecs[5]  = '{2'd1, 4'd11, 3'd1};
        vecs[6]  = '{2'd2, 4'd12, 3'd2};
        vecs[7]  = '{2'd3, 4'd7,  3'd2};
        vecs[8]  = '{2'd0, 4'd9,  3'd4};
        vecs[9]  = '{2'd1, 4'd13, 3'd3};
        vecs[10] = '{2'd2, 4'd4,  3'd4};
        vecs[11] = '{2'd3, 4'd10, 3'd0};

        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_zero_outputs("reset");

        // Table-driven single transactions.
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            post(int'(vecs[i].ch), vecs[i].data, vecs[i].rest);
            tick();
            check("vec_ack", 32'(ack), 32'(4'b0001 << vecs[i].ch));
            drain(20);
            check("vec_done_count", 32'(done_count), 32'(exp_done));
        end

        // All four requesters at once: served ch0..ch3 in order.
        post(0, 4'd13, 3'd3);
        post(1, 4'd10, 3'd0);
        post(2, 4'd3,  3'd3);
        post(3, 4'd9,  3'd4);
        tick();
        check("all_first_ack", 32'(ack), 32'd1);
        drain(40);
        check("all_done_count", 32'(done_count), 32'(exp_done));

        // Backpressure: result held, and a req raised in HOLD waits for the handshake.
        res_ready = 1'b0;
        post(0, 4'd15, 3'd0);
        tick();
        check("bp_ack", 32'(ack), 32'd1);
        tick();
        post(1, 4'd7, 3'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_rest", 32'(res_rest), 32'd0);
            check("bp_res_zero", 32'(res_zero), 32'd1);
            check("bp_res_ch", 32'(res_ch), 32'd0);
            check("bp_no_ack", 32'(ack), 32'd0);
        end
        res_ready = 1'b1;
        drain(20);

        // Wrap: after ch2 the pointer sits at 3, so ch3 beats ch0.
        post(2, 4'd2, 3'd2);
        tick();
        check("wrap_ch2_ack", 32'(ack), 32'd4);
        drain(20);
        post(3, 4'd8, 3'd3);
        post(0, 4'd1, 3'd1);
        tick();
        check("wrap_ch3_first_ack", 32'(ack), 32'd8);
        drain(30);

        // Reset while holding a result; the still-held req is granted again.
        auto_drop = 1'b0;
        res_ready = 1'b0;
        post(1, 4'd7, 3'd2);
        tick();
        check("rst_pre_ack", 32'(ack), 32'd2);
        tick();
        check("rst_pre_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_zero_outputs("mid_reset");
        exp_q.delete();
        exp_done = 0;
        rst = 1'b0;
        auto_drop = 1'b1;
        res_ready = 1'b1;
        post(1, 4'd7, 3'd2);
        tick();
        check("regrant_ack", 32'(ack), 32'd2);
        check("regrant_sensor_input", 32'(sensor_input), 32'd7);
        drain(20);
        check("regrant_done_count", 32'(done_count), 32'd1);

        // Faulty shared unit sets the sticky error.
        bad = 1'b1;
        post(2, 4'd3, 3'd6);
        drain(20);
        bad = 1'b0;
        check("err_set", 32'(err), 32'd1);

        // Many good results: err stays, counter saturates.
        for (int k = 0; k < 300; k++) begin
            d = 4'(k % 16);
            post(k % 4, d, 3'(d % 4'd5));
            drain(20);
        end
        check("err_sticky", 32'(err), 32'd1);
        check("done_model", 32'(done_count), 32'(exp_done));
        check("done_saturated", 32'(done_count), 32'd255);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_cleared", 32'(err), 32'd0);
        check("done_cleared", 32'(done_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
